// File: rtl/gpio_pkg.sv
// Shared defaults and types for the GPIO input-conditioning slice.
// Imported by the interface, the per-pin cell and the top.
package gpio_pkg;

   localparam int PERIPH_GPIO_NUM  = 16;
   localparam int GPIO_SYNC_STAGES = 2;
   localparam int GPIO_DB_CNT_W    = 8;

   typedef logic [PERIPH_GPIO_NUM-1:0] gpio_vec_t;
   typedef logic [GPIO_DB_CNT_W-1:0]   gpio_db_cnt_t;

endpackage

// File: rtl/gpio_in_cond_if.sv
// Pad-side and gpio_top-side signals of the input conditioner.
// There is no valid/ready handshake: pads and config are level inputs, events are one-cycle pulses.
interface gpio_in_cond_if
   import gpio_pkg::*;
#(
   parameter int N = PERIPH_GPIO_NUM,
   parameter int W = GPIO_DB_CNT_W
) ();

   logic [N-1:0] pad_in;
   logic [N-1:0] cfg_db_en;
   logic [W-1:0] cfg_db_limit;
   logic [N-1:0] gpio_in;
   logic [N-1:0] rise_evt;
   logic [N-1:0] fall_evt;

   modport master (
      output pad_in, cfg_db_en, cfg_db_limit,
      input  gpio_in, rise_evt, fall_evt
   );

   modport slave (
      input  pad_in, cfg_db_en, cfg_db_limit,
      output gpio_in, rise_evt, fall_evt
   );

endinterface

// File: rtl/gpio_in_pin.sv
// One pin: synchroniser chain, debounce filter on the synchronised level, edge pulses.
// busy is high while the pin is not settled, so the clock gate must stay open.
module gpio_in_pin
   import gpio_pkg::*;
#(
   parameter int SYNC_STAGES = GPIO_SYNC_STAGES,
   parameter int DB_CNT_W    = GPIO_DB_CNT_W
) (
   input  logic                g_clk,
   input  logic                g_reset,
   input  logic                pad,
   input  logic                db_en,
   input  logic [DB_CNT_W-1:0] db_limit,
   output logic                s,
   output logic                rise,
   output logic                fall,
   output logic                busy
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [DB_CNT_W-1:0]    cnt_q, cnt_d;
   logic                   s_q, s_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   sync_lvl;

   assign sync_lvl = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], pad};
      s_d    = s_q;
      cnt_d  = cnt_q;
      if (sync_lvl == s_q) begin
         cnt_d = '0;
      // >= rather than == so a limit lowered mid-count still releases at once
      end else if ((cnt_q >= db_limit) || !db_en) begin
         s_d   = sync_lvl;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + DB_CNT_W'(1);
      end
      rise_d = !s_q && s_d;
      fall_d = s_q && !s_d;
   end

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         sync_q <= '0;
         cnt_q  <= '0;
         s_q    <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         s_q    <= s_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign s    = s_q;
   assign rise = rise_q;
   assign fall = fall_q;
   // Combinational on purpose: the request must rise before the gated clock runs.
   assign busy = (pad != s_q) || (|(sync_q ^ {SYNC_STAGES{s_q}})) || (cnt_q != '0);

endmodule

// File: rtl/gpio_in_cond.sv
// GPIO input conditioner: one gpio_in_pin per pin, shared debounce limit,
// and a clock request that stays high while any pin is unsettled.
module gpio_in_cond
   import gpio_pkg::*;
#(
   parameter int PERIPH_GPIO_NUM = gpio_pkg::PERIPH_GPIO_NUM,
   parameter int SYNC_STAGES     = GPIO_SYNC_STAGES,
   parameter int DB_CNT_W        = GPIO_DB_CNT_W
) (
   input  logic          g_clk,
   input  logic          g_reset,
   output logic          g_clk_req,
   gpio_in_cond_if.slave io
);

   logic [PERIPH_GPIO_NUM-1:0] busy;

   for (genvar i = 0; i < PERIPH_GPIO_NUM; i++) begin : g_pin
      gpio_in_pin #(
         .SYNC_STAGES (SYNC_STAGES),
         .DB_CNT_W    (DB_CNT_W)
      ) u_pin (
         .g_clk    (g_clk),
         .g_reset  (g_reset),
         .pad      (io.pad_in[i]),
         .db_en    (io.cfg_db_en[i]),
         .db_limit (io.cfg_db_limit),
         .s        (io.gpio_in[i]),
         .rise     (io.rise_evt[i]),
         .fall     (io.fall_evt[i]),
         .busy     (busy[i])
      );
   end

   assign g_clk_req = |busy;

endmodule

// File: tb/tb_gpio_in_cond.sv
// Directed bench for gpio_in_cond: vector table for bypass and simultaneous edges,
// hand sequences for reset latency, glitch rejection, limit shrink and async reset.
module tb_gpio_in_cond;
  import gpio_pkg::*;

  typedef struct {
    logic [15:0] pad;
    logic [15:0] db_en;
    logic [7:0]  limit;
    int          cycles;
    logic [15:0] exp_gpio;
    logic [15:0] exp_rise;
    logic [15:0] exp_fall;
    logic        exp_req;
  } vec_t;

  logic g_clk = 1'b0;
  logic g_reset;
  logic g_clk_req;

  gpio_in_cond_if #(.N(16), .W(8)) io ();

  gpio_in_cond #(
    .PERIPH_GPIO_NUM (16),
    .SYNC_STAGES     (2),
    .DB_CNT_W        (8)
  ) dut (
    .g_clk     (g_clk),
    .g_reset   (g_reset),
    .g_clk_req (g_clk_req),
    .io        (io)
  );

  // clock / reset
  always #5 g_clk = ~g_clk;

  int tests = 0;
  int fails = 0;
  vec_t vecs[$];

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge g_clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [15:0] g, input logic [15:0] r,
                           input logic [15:0] f, input logic q);
    check({name, ".gpio_in"}, io.gpio_in, g);
    check({name, ".rise_evt"}, io.rise_evt, r);
    check({name, ".fall_evt"}, io.fall_evt, f);
    check({name, ".g_clk_req"}, {15'd0, g_clk_req}, {15'd0, q});
  endtask

  function automatic vec_t mk(input logic [15:0] pad, input logic [15:0] en, input logic [7:0] lim,
                              input int cyc, input logic [15:0] g, input logic [15:0] r,
                              input logic [15:0] f, input logic q);
    vec_t v;
    v.pad = pad; v.db_en = en; v.limit = lim; v.cycles = cyc;
    v.exp_gpio = g; v.exp_rise = r; v.exp_fall = f; v.exp_req = q;
    return v;
  endfunction

  initial begin
    // ---- reset with pads high ----
    g_reset = 1'b1;
    io.pad_in = 16'h00FF;
    io.cfg_db_en = 16'hFFFF;
    io.cfg_db_limit = 8'd3;
    #3;
    check_all("in_reset", 16'h0000, 16'h0000, 16'h0000, 1'b1);
    tick(1);
    g_reset = 1'b0;
    tick(5);
    check_all("rst_lat5", 16'h0000, 16'h0000, 16'h0000, 1'b1);
    tick(1);
    check_all("rst_lat6", 16'h00FF, 16'h00FF, 16'h0000, 1'b0);
    tick(1);
    check_all("rst_lat7", 16'h00FF, 16'h0000, 16'h0000, 1'b0);

    // ---- table: clear, simultaneous edges (limit 0), pin 5 bypass (limit 200) ----
    vecs.push_back(mk(16'h0000, 16'hFFFF, 8'd0,   3, 16'h0000, 16'h0000, 16'h00FF, 1'b0));
    vecs.push_back(mk(16'hFFFF, 16'hFFFF, 8'd0,   2, 16'h0000, 16'h0000, 16'h0000, 1'b1));
    vecs.push_back(mk(16'hFFFF, 16'hFFFF, 8'd0,   1, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0));
    vecs.push_back(mk(16'hFFFF, 16'hFFFF, 8'd0,   1, 16'hFFFF, 16'h0000, 16'h0000, 1'b0));
    vecs.push_back(mk(16'h0000, 16'hFFFF, 8'd0,   2, 16'hFFFF, 16'h0000, 16'h0000, 1'b1));
    vecs.push_back(mk(16'h0000, 16'hFFFF, 8'd0,   1, 16'h0000, 16'h0000, 16'hFFFF, 1'b0));
    vecs.push_back(mk(16'h0000, 16'hFFFF, 8'd0,   1, 16'h0000, 16'h0000, 16'h0000, 1'b0));
    vecs.push_back(mk(16'h0020, 16'hFFDF, 8'd200, 2, 16'h0000, 16'h0000, 16'h0000, 1'b1));
    vecs.push_back(mk(16'h0020, 16'hFFDF, 8'd200, 1, 16'h0020, 16'h0020, 16'h0000, 1'b0));
    vecs.push_back(mk(16'h0020, 16'hFFDF, 8'd200, 7, 16'h0020, 16'h0000, 16'h0000, 1'b0));
    vecs.push_back(mk(16'h0000, 16'hFFDF, 8'd200, 2, 16'h0020, 16'h0000, 16'h0000, 1'b1));
    vecs.push_back(mk(16'h0000, 16'hFFDF, 8'd200, 1, 16'h0000, 16'h0000, 16'h0020, 1'b0));
    vecs.push_back(mk(16'h0000, 16'hFFDF, 8'd200, 1, 16'h0000, 16'h0000, 16'h0000, 1'b0));
    foreach (vecs[i]) begin
      io.pad_in = vecs[i].pad;
      io.cfg_db_en = vecs[i].db_en;
      io.cfg_db_limit = vecs[i].limit;
      tick(vecs[i].cycles);
      check_all($sformatf("vec%0d", i), vecs[i].exp_gpio, vecs[i].exp_rise,
                vecs[i].exp_fall, vecs[i].exp_req);
    end

    // ---- glitch: 3-cycle pulse on pin 0, limit 4 ----
    io.cfg_db_en = 16'hFFFF;
    io.cfg_db_limit = 8'd4;
    io.pad_in = 16'h0001;
    tick(3);
    io.pad_in = 16'h0000;
    tick(1);
    check_all("glitch_mid", 16'h0000, 16'h0000, 16'h0000, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check($sformatf("glitch_gpio%0d", k), io.gpio_in, 16'h0000);
      check($sformatf("glitch_rise%0d", k), io.rise_evt, 16'h0000);
    end
    check("glitch_req_drained", {15'd0, g_clk_req}, 16'h0000);

    // ---- limit shrink mid-count on pin 2 ----
    io.cfg_db_limit = 8'd100;
    io.pad_in = 16'h0004;
    tick(42);
    check_all("shrink_before", 16'h0000, 16'h0000, 16'h0000, 1'b1);
    io.cfg_db_limit = 8'd10;
    tick(1);
    check_all("shrink_rise", 16'h0004, 16'h0004, 16'h0000, 1'b0);
    tick(1);
    check_all("shrink_after", 16'h0004, 16'h0000, 16'h0000, 1'b0);

    // ---- async reset mid-count on pin 7, limit 8 ----
    io.cfg_db_limit = 8'd8;
    io.pad_in = 16'h000C;
    tick(11);
    check_all("pin3_up", 16'h000C, 16'h0008, 16'h0000, 1'b0);
    io.pad_in = 16'h008C;
    tick(7);
    check_all("pin7_counting", 16'h000C, 16'h0000, 16'h0000, 1'b1);
    #2 g_reset = 1'b1;
    #1;
    check_all("async_rst", 16'h0000, 16'h0000, 16'h0000, 1'b1);
    tick(1);
    g_reset = 1'b0;
    tick(10);
    check_all("rerel10", 16'h0000, 16'h0000, 16'h0000, 1'b1);
    tick(1);
    check_all("rerel11", 16'h008C, 16'h008C, 16'h0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gpio_in_cond.md
Name: gpio_in_cond

Overview:
- Input-conditioning stage between the GPIO pads and gpio_top's gpio_in port.
- Per pin: metastability synchroniser, programmable debounce filter, rising/falling edge-event pulses.
- Produces the clean level vector gpio_in that gpio_top consumes, plus single-cycle edge events for a later interrupt/capture stage.
- Raises a clock request while any pin is unsettled, so the gated clock can stay off when pins are quiet.

Parameters:
- PERIPH_GPIO_NUM, 16, number of GPIO pins (GPION = PERIPH_GPIO_NUM-1).
- SYNC_STAGES, 2, synchroniser flops per pin; legal range 2..4.
- DB_CNT_W, 8, debounce counter and limit width.

Ports:
- g_clk  in  1  gated clock.
- g_reset  in  1  asynchronous active-high reset.
- g_clk_req  out  1  clock request; high while any pin unsettled.
- pad_in  in  [GPION:0]  raw asynchronous pad inputs.
- cfg_db_en  in  [GPION:0]  per-pin debounce enable; 0 = bypass filter.
- cfg_db_limit  in  [DB_CNT_W-1:0]  shared debounce limit, quasi-static.
- gpio_in  out  [GPION:0]  conditioned stable levels, to gpio_top.gpio_in.
- rise_evt  out  [GPION:0]  one-cycle pulse on a 0->1 stable transition.
- fall_evt  out  [GPION:0]  one-cycle pulse on a 1->0 stable transition.

Behaviour:
- Reset (async assert, sync-released by the system): all sync flops, counters, gpio_in, rise_evt and fall_evt are 0. g_clk_req is then 0 unless pad_in is nonzero.
- Synchroniser: the per-pin chain of SYNC_STAGES flops gives sync_q, delayed SYNC_STAGES cycles from pad_in.
- Debounce, per pin, with stable value s (= gpio_in bit) and counter c:
  - sync_q == s: c <= 0.
  - sync_q != s and (c >= cfg_db_limit or cfg_db_en == 0): s <= sync_q, c <= 0.
  - otherwise: c <= c + 1.
  - The >= compare means c never overflows and a mid-count limit reduction takes effect immediately.
- Latency pad -> gpio_in: SYNC_STAGES + cfg_db_limit + 1 cycles with debounce enabled; SYNC_STAGES + 1 when bypassed or cfg_db_limit = 0.
- Glitch rejection: a sync_q excursion shorter than cfg_db_limit+1 cycles never changes s; the counter clears on return.
- Edge events, registered in the same cycle s updates:
  - rise_evt bit = 1 for exactly one cycle in which gpio_in goes 0->1.
  - fall_evt bit = 1 for exactly one cycle in which gpio_in goes 1->0.
  - rise_evt and fall_evt are never both high for one pin.
  - Consecutive transitions on a pin are at least 1 cycle apart, so pulses never merge.
- Toggling cfg_db_en mid-count: the bypass condition applies on the next edge; the counter clears on update.
- g_clk_req = OR over pins of (pad_in != s) | (any sync stage != s) | (c != 0). This is combinational, may glitch, and is for clock-gate request only.
- All pins are independent; simultaneous transitions on several pins produce simultaneous events.
- Reset mid-debounce: the count is discarded and gpio_in returns to 0. After release a high pad re-qualifies with full latency and gives a rise_evt.

Decomposition:
- Shared package gpio_pkg holds:
  - PERIPH_GPIO_NUM default
  - GPIO_SYNC_STAGES default
  - GPIO_DB_CNT_W default
  - typedef gpio_vec_t (logic [PERIPH_GPIO_NUM-1:0])
  - typedef gpio_db_cnt_t.
- Sub-module gpio_in_pin: one pin's synchroniser + debounce + edge logic; outputs s, rise, fall, busy.
- gpio_in_cond instantiates PERIPH_GPIO_NUM copies via generate, ORs the busy outputs into g_clk_req, and fans out cfg_db_limit.

Test Plan:
- Reset with pad_in=16'h00FF held high: all outputs 0 during reset. Release, db_en=all 1, limit=3: gpio_in=16'h00FF exactly 2+3+1=6 cycles after release; rise_evt=16'h00FF for 1 cycle; g_clk_req low afterwards.
- Glitch: limit=4, pin 0 pulses high 3 cycles at sync output: gpio_in[0] stays 0, no events, counter returns to 0, g_clk_req falls after the pulse drains.
- Bypass: cfg_db_en[5]=0, limit=200, pad 0->1->0 with 10-cycle high: gpio_in[5] follows 3 cycles after the pad; one rise_evt and one fall_evt, each 1 cycle, 10 cycles apart.
- Limit shrink mid-count: limit=100, pin 2 held high 40 cycles, then limit set to 10: gpio_in[2] rises the next cycle (c=40 >= 10), single rise_evt.
- Simultaneous edges: pins 0..15 toggle together, limit=0: all gpio_in bits change in one cycle, rise_evt=16'hFFFF, then on the reverse toggle fall_evt=16'hFFFF.
- Async reset asserted mid-count (pin 7, c=5, limit=8): gpio_in and events clear immediately without a clock edge. After release with the pad still high, gpio_in[7] rises after 2+8+1=11 cycles.
